fifo_rd_stream: RTL
===================

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width in bits, shared with the upstream FIFO.
REQ-002 SHALL have parameter PKT_LEN, default 256: beats per packet; legal range 1..65536.
REQ-003 SHALL use one clock; reset is asynchronous and active-low. Ports are named i_clk and i_rst_n.
REQ-004 SHALL have ports:
- i_clk  input  1  block clock, shared with the upstream FIFO read side.
- i_rst_n  input  1  asynchronous active-low reset.
- o_rd_en  output  1  read strobe to the upstream FIFO.
- i_rd_data  input  WIDTH  FIFO read data, valid the cycle after o_rd_en (non-FWFT, latency 1).
- i_rd_empty  input  1  FIFO empty flag.
- o_tvalid  output  1  stream beat valid.
- i_tready  input  1  stream sink ready.
- o_tdata  output  WIDTH  stream beat data.
- o_tlast  output  1  last beat of a packet.
- o_pkt_cnt  output  16  completed packet count.

Function
REQ-005 SHALL contain a 3-entry in-order output buffer with an occupancy count occ (0..3).
REQ-006 SHALL keep an in-flight flag f, registered from o_rd_en; f=1 means FIFO data arrives this cycle.
REQ-007 SHALL drive o_rd_en = !i_rd_empty && (occ + f) < 3.
- o_rd_en SHALL depend on registered state and i_rd_empty only.
- There SHALL be no combinational path from i_tready to o_rd_en.
REQ-008 SHALL push i_rd_data into the buffer tail at the clock edge where f=1, whatever the state of i_rd_empty.
REQ-009 SHALL drive o_tvalid = (occ != 0) and o_tdata = buffer head.
REQ-010 A handshake SHALL be o_tvalid && i_tready; it pops the head.
REQ-011 On a simultaneous push and pop, occ SHALL stay unchanged and order SHALL be preserved.
- The buffer SHALL never overflow; an overflow is a design error and SHALL be flagged by an assertion.
REQ-012 While o_tvalid=1 and i_tready=0, o_tdata and o_tlast SHALL hold stable.
REQ-013 Latency: first o_tvalid SHALL assert 2 cycles after the first o_rd_en when the buffer is empty.
REQ-014 Sustained throughput SHALL be 1 beat/cycle while the FIFO is non-empty and i_tready=1.
REQ-015 SHALL keep a beat counter of width max(1, ceil(log2(PKT_LEN))) that counts handshakes.
- o_tlast = o_tvalid && (beat_cnt == PKT_LEN-1).
- The counter SHALL wrap to 0 on the last-beat handshake.
REQ-016 PKT_LEN=1: o_tlast SHALL equal o_tvalid on every beat.
REQ-017 o_pkt_cnt SHALL increment by 1 on each last-beat handshake, visible the next cycle.
- It SHALL wrap 65535 -> 0.
REQ-018 FIFO going empty mid-packet SHALL only gap o_tvalid; beat_cnt and packet framing SHALL continue when data resumes.

Reset
REQ-019 i_rst_n=0 SHALL asynchronously clear occ, f, the buffer pointers, beat_cnt and o_pkt_cnt.
REQ-020 During reset, outputs SHALL be: o_rd_en=0, o_tvalid=0, o_tlast=0, o_pkt_cnt=0, o_tdata=0.
REQ-021 Reset mid-operation SHALL discard buffered and in-flight data.
- Framing SHALL restart at beat 0.
- Upstream FIFO reset is the integrator's responsibility.
REQ-022 After i_rst_n deasserts, o_rd_en SHALL assert no earlier than the first i_clk rising edge.

Verification
REQ-023 The bench SHALL cover:
- Reset held with i_rd_empty=0 -> o_rd_en=0, o_tvalid=0, o_pkt_cnt=0.
- FIFO preloaded with 512 words 0..511, i_tready=1 -> o_tvalid rises 2 cycles after the first o_rd_en. Then 512 consecutive beats with o_tdata 0..511. o_tlast on beats 255 and 511. o_pkt_cnt=2.
- FIFO full, i_tready=0 -> exactly 3 o_rd_en pulses, then o_rd_en=0. o_tdata=0 stays stable. Raising i_tready resumes 1..n with no loss or duplicate.
- i_tready toggling 1,0,1,0 with FIFO writes at half rate -> output sequence strictly incrementing. o_tlast every 256th beat. No protocol violation.
- i_rst_n pulsed low after beat 100 of packet 0 -> o_tvalid=0 immediately. After refill, the next o_tlast is on the 256th beat following reset. o_pkt_cnt restarts from 0.
- PKT_LEN=1, 4 words -> o_tlast on all 4 beats. o_pkt_cnt=4.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// Drains a non-FWFT FIFO (read latency 1) into a valid/ready stream
// with fixed-length packet framing and a completed-packet counter.
module fifo_rd_stream #(
    parameter int WIDTH   = 32,
    parameter int PKT_LEN = 256
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    output logic             o_rd_en,
    input  logic [WIDTH-1:0] i_rd_data,
    input  logic             i_rd_empty,
    output logic             o_tvalid,
    input  logic             i_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tlast,
    output logic [15:0]      o_pkt_cnt
);

    localparam int CW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(PKT_LEN - 1);

    logic [WIDTH-1:0] mem_q [3];
    logic [1:0]       wr_ptr_q;
    logic [1:0]       rd_ptr_q;
    logic [1:0]       occ_q;
    logic [1:0]       occ_d;
    logic             f_q;
    logic             run_q;
    logic [CW-1:0]    beat_q;
    logic [15:0]      pkt_q;
    logic             push;
    logic             pop;

    function automatic logic [1:0] inc3(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Reads count buffered and in-flight words, so the buffer never overflows.
    // run_q keeps o_rd_en low until the first edge after reset release.
    assign push      = f_q;
    assign o_tvalid  = (occ_q != 2'd0);
    assign pop       = o_tvalid && i_tready;
    assign o_rd_en   = run_q && !i_rd_empty
                       && (({1'b0, occ_q} + {2'b00, f_q}) < 3'd3);
    assign o_tdata   = o_tvalid ? mem_q[rd_ptr_q] : '0;
    assign o_tlast   = o_tvalid && (beat_q == LAST);
    assign o_pkt_cnt = pkt_q;

    always_comb begin
        occ_d = occ_q;
        unique case (1'b1)
            push && !pop: occ_d = occ_q + 2'd1;
            pop && !push: occ_d = occ_q - 2'd1;
            default:      occ_d = occ_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_rd_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            occ_q    <= 2'd0;
            f_q      <= 1'b0;
            run_q    <= 1'b0;
            beat_q   <= '0;
            pkt_q    <= 16'd0;
        end else begin
            run_q <= 1'b1;
            f_q   <= o_rd_en;
            occ_q <= occ_d;
            if (push) begin
                wr_ptr_q <= inc3(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= inc3(rd_ptr_q);
                if (beat_q == LAST) begin
                    beat_q <= '0;
                    pkt_q  <= pkt_q + 16'd1;
                end else begin
                    beat_q <= beat_q + 1'b1;
                end
            end
        end
    end

    a_no_overflow: assert property (
        @(posedge i_clk) disable iff (!i_rst_n)
        !(push && !pop && occ_q == 2'd3)
    );

endmodule
